// File: rtl/ascii_pkg.sv
// Shared ASCII constants and the output-buffer occupancy states for the
// lower-case stream converter.
package ascii_pkg;

   localparam logic [7:0] ASCII_UC_A     = 8'h41;
   localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
   localparam int         ASCII_CASE_BIT = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/ascii_case_detect.sv
// Combinational upper-case detector: flags 'A'..'Z' and produces the byte
// with the case bit set; any other byte passes through untouched.
module ascii_case_detect
   import ascii_pkg::*;
(
   input  logic [7:0] data_i,
   output logic       is_upper_o,
   output logic [7:0] lower_o
);

   // Bytes with bit 7 set fall outside the range, so they are never converted.
   assign is_upper_o = (data_i >= ASCII_UC_A) && (data_i <= ASCII_UC_Z);
   assign lower_o    = is_upper_o ? (data_i | (8'h01 << ASCII_CASE_BIT)) : data_i;

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII lower-caser with a two-entry registered output buffer and
// saturating byte / conversion counters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and payload is held while valid && !ready.
module to_lower_stream
   import ascii_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             out_conv,
   input  logic             clear_counts,
   output logic [CNT_W-1:0] byte_count,
   output logic [CNT_W-1:0] conv_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       det_upper;
   logic [7:0] det_lower;

   ascii_case_detect u_det (
      .data_i     (in_data),
      .is_upper_o (det_upper),
      .lower_o    (det_lower)
   );

   buf_state_e       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [7:0]       head_data_q, head_data_d;
   logic             head_last_q, head_last_d;
   logic             head_conv_q, head_conv_d;
   logic [7:0]       tail_data_q, tail_data_d;
   logic             tail_last_q, tail_last_d;
   logic             tail_conv_q, tail_conv_d;
   logic [CNT_W-1:0] byte_count_q, byte_count_d;
   logic [CNT_W-1:0] conv_count_q, conv_count_d;

   logic             in_acc;
   logic             out_acc;
   logic [CNT_W-1:0] byte_base;
   logic [CNT_W-1:0] conv_base;

   assign in_acc  = in_valid && in_ready_q;
   assign out_acc = (state_q != EMPTY) && out_ready;

   // The head entry drives the outputs directly; the tail only fills when the
   // sink stalls with one byte already waiting.
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      head_conv_d = head_conv_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      tail_conv_d = tail_conv_q;
      case (state_q)
         EMPTY: begin
            if (in_acc) begin
               head_data_d = det_lower;
               head_last_d = in_last;
               head_conv_d = det_upper;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (in_acc && out_acc) begin
               head_data_d = det_lower;
               head_last_d = in_last;
               head_conv_d = det_upper;
            end else if (in_acc) begin
               tail_data_d = det_lower;
               tail_last_d = in_last;
               tail_conv_d = det_upper;
               state_d     = FULL;
            end else if (out_acc) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_acc) begin
               head_data_d = tail_data_q;
               head_last_d = tail_last_q;
               head_conv_d = tail_conv_q;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d = (state_d != FULL);
   end

   // A clear coinciding with an accept restarts the count from zero and still
   // counts the accepted byte.
   always_comb begin
      byte_base    = clear_counts ? '0 : byte_count_q;
      conv_base    = clear_counts ? '0 : conv_count_q;
      byte_count_d = byte_base;
      conv_count_d = conv_base;
      if (in_acc && (byte_base != CNT_MAX)) byte_count_d = byte_base + CNT_ONE;
      if (in_acc && det_upper && (conv_base != CNT_MAX)) conv_count_d = conv_base + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         in_ready_q   <= 1'b0;
         head_data_q  <= 8'h00;
         head_last_q  <= 1'b0;
         head_conv_q  <= 1'b0;
         tail_data_q  <= 8'h00;
         tail_last_q  <= 1'b0;
         tail_conv_q  <= 1'b0;
         byte_count_q <= '0;
         conv_count_q <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         head_data_q  <= head_data_d;
         head_last_q  <= head_last_d;
         head_conv_q  <= head_conv_d;
         tail_data_q  <= tail_data_d;
         tail_last_q  <= tail_last_d;
         tail_conv_q  <= tail_conv_d;
         byte_count_q <= byte_count_d;
         conv_count_q <= conv_count_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != EMPTY);
   assign out_data   = head_data_q;
   assign out_last   = head_last_q;
   assign out_conv   = head_conv_q;
   assign byte_count = byte_count_q;
   assign conv_count = conv_count_q;

endmodule

// File: tb/tb_to_lower_stream.sv
// Bench for to_lower_stream: a 16-bit and a 4-bit counter instance share the
// same stimulus and are checked every cycle against a queue-based model.
module tb_to_lower_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, in_last, out_ready, clear_counts;
   logic [7:0] in_data;

   logic        in_ready, out_valid, out_last, out_conv;
   logic [7:0]  out_data;
   logic [15:0] byte_count, conv_count;

   logic        in_ready4, out_valid4, out_last4, out_conv4;
   logic [7:0]  out_data4;
   logic [3:0]  byte_count4, conv_count4;

   to_lower_stream dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .out_conv(out_conv), .clear_counts(clear_counts),
      .byte_count(byte_count), .conv_count(conv_count)
   );

   to_lower_stream #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4),
      .out_conv(out_conv4), .clear_counts(clear_counts),
      .byte_count(byte_count4), .conv_count(conv_count4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a byte is upper case when it lies in 'A'..'Z'; lowering adds 32.
   function automatic logic [9:0] model_byte(input logic [7:0] d, input logic l);
      logic up;
      up = (d >= 8'h41) && (d <= 8'h5A);
      return {l, up, up ? d + 8'd32 : d};
   endfunction

   function automatic int sat_next(input int cur, input logic clr, input logic inc, input int maxv);
      int b;
      b = clr ? 0 : cur;
      if (inc && b < maxv) b++;
      return b;
   endfunction

   logic [9:0] exp_q[$];  // {last, conv, data}
   logic [9:0] rec_q[$];  // bytes actually handed to the sink
   logic       m_rdy;
   int         m_bc16, m_cc16, m_bc4, m_cc4;
   bit         chk_en = 0;

   always @(posedge clk) begin : model
      logic       acc, pop;
      logic [9:0] nb;
      if (!rst && out_valid && out_ready) rec_q.push_back({out_last, out_conv, out_data});
      if (rst) begin
         exp_q.delete();
         m_rdy  = 1'b0;
         m_bc16 = 0; m_cc16 = 0; m_bc4 = 0; m_cc4 = 0;
         chk_en = 1;
      end else begin
         acc = in_valid && m_rdy;
         pop = (exp_q.size() > 0) && out_ready;
         nb  = model_byte(in_data, in_last);
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(nb);
         m_bc16 = sat_next(m_bc16, clear_counts, acc, 65535);
         m_cc16 = sat_next(m_cc16, clear_counts, acc && nb[8], 65535);
         m_bc4  = sat_next(m_bc4, clear_counts, acc, 15);
         m_cc4  = sat_next(m_cc4, clear_counts, acc && nb[8], 15);
         m_rdy  = (exp_q.size() < 2);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_rdy);
         chk("in_ready4", in_ready4, m_rdy);
         chk("out_valid", out_valid, exp_q.size() > 0);
         chk("out_valid4", out_valid4, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            chk("out_word", {out_last, out_conv, out_data}, exp_q[0]);
            chk("out_word4", {out_last4, out_conv4, out_data4}, exp_q[0]);
         end
         chk("byte_count", byte_count, m_bc16);
         chk("conv_count", conv_count, m_cc16);
         chk("byte_count4", byte_count4, m_bc4);
         chk("conv_count4", conv_count4, m_cc4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int  n;
      logic took;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      do begin
         took = in_ready;
         tick();
         n++;
      end while (!took && n < 200);
      chk("send_accept", took, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      string       s_in, s_out;
      logic [7:0]  bnd_in  [6];
      logic [7:0]  bnd_out [6];
      logic        bnd_conv[6];

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      out_ready = 1'b0; clear_counts = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Randomised traffic with a mid-stream reset
      for (int c = 0; c < 1500; c++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_data      = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h3F, 8'h5C))
                                                     : 8'($urandom_range(0, 255));
         in_last      = ($urandom_range(0, 7) == 0);
         out_ready    = ($urandom_range(0, 9) < 7);
         clear_counts = ($urandom_range(0, 49) == 0);
         if (c == 700) begin
            rst = 1'b1;
            in_valid = 1'b0;
            for (int r = 0; r < 2; r++) begin
               tick();
               chk("rst_out_valid", out_valid, 1'b0);
               chk("rst_in_ready", in_ready, 1'b0);
               chk("rst_out_data", out_data, 8'h00);
               chk("rst_out_last", out_last, 1'b0);
               chk("rst_out_conv", out_conv, 1'b0);
               chk("rst_byte_count", byte_count, 16'd0);
               chk("rst_conv_count", conv_count, 16'd0);
            end
            rst = 1'b0;
            clear_counts = 1'b0;
            tick();
            chk("post_rst_in_ready", in_ready, 1'b1);
            chk("post_rst_out_valid", out_valid, 1'b0);
         end else begin
            tick();
         end
      end
      in_valid = 1'b0; clear_counts = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      // Sentence stream at full rate
      s_in  = "Hello, WORLD!";
      s_out = "hello, world!";
      pulse_clear();
      rec_q.delete();
      for (int i = 0; i < s_in.len(); i++) send(s_in[i], 1'b0);
      repeat (3) tick();
      chk("str_len", rec_q.size(), 13);
      for (int i = 0; i < 13 && i < rec_q.size(); i++) chk("str_byte", rec_q[i][7:0], s_out[i]);
      chk("str_byte_count", byte_count, 16'd13);
      chk("str_conv_count", conv_count, 16'd6);

      // Case boundaries
      bnd_in  = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h61, 8'hC1};
      bnd_out = '{8'h40, 8'h61, 8'h7A, 8'h5B, 8'h61, 8'hC1};
      bnd_conv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      rec_q.delete();
      for (int i = 0; i < 6; i++) send(bnd_in[i], 1'b0);
      repeat (3) tick();
      chk("bnd_len", rec_q.size(), 6);
      for (int i = 0; i < 6 && i < rec_q.size(); i++) begin
         chk("bnd_data", rec_q[i][7:0], bnd_out[i]);
         chk("bnd_conv", rec_q[i][8], bnd_conv[i]);
      end

      // Backpressure: three pushes into a stalled sink
      rec_q.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_last = 1'b0;
      in_data = 8'h4B; tick();
      in_data = 8'h6C; tick();
      in_data = 8'h4D;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_data", out_data, 8'h6B);
      tick(); tick();
      chk("bp_in_ready_hold", in_ready, 1'b0);
      chk("bp_out_data_hold", out_data, 8'h6B);
      chk("bp_out_valid_hold", out_valid, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("bp_len", rec_q.size(), 2);
      if (rec_q.size() == 2) begin
         chk("bp_first", rec_q[0][7:0], 8'h6B);
         chk("bp_second", rec_q[1][7:0], 8'h6C);
      end

      // Frame marker on the fourth byte only
      rec_q.delete();
      send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b1);
      repeat (3) tick();
      chk("last_len", rec_q.size(), 4);
      for (int i = 0; i < 4 && i < rec_q.size(); i++) begin
         chk("last_data", rec_q[i][7:0], 8'h61 + 8'(i));
         chk("last_flag", rec_q[i][9], i == 3);
      end

      // Saturation of the narrow counters, then clear with a coincident accept
      pulse_clear();
      for (int i = 0; i < 20; i++) send(8'h41 + 8'(i % 26), 1'b0);
      repeat (3) tick();
      chk("sat_byte_count4", byte_count4, 4'd15);
      chk("sat_conv_count4", conv_count4, 4'd15);
      chk("sat_byte_count16", byte_count, 16'd20);
      chk("sat_conv_count16", conv_count, 16'd20);
      clear_counts = 1'b1;
      send(8'h51, 1'b0);
      clear_counts = 1'b0;
      chk("clr_byte_count4", byte_count4, 4'd1);
      chk("clr_conv_count4", conv_count4, 4'd1);
      chk("clr_byte_count16", byte_count, 16'd1);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
